// File: rtl/dcm_lock_ctrl.sv
// Bring-up sequencer for a cascaded DCM pair: pulses U2 reset, waits for lock, settles, releases SYS_RST.
// Define DCM_LOCK_LOSS_CNT_EN to implement the RUN lock-loss counter; otherwise LOSS_CNT is tied to 0.
module dcm_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic       BUS_CLK,
  input  logic       BUS_RST_N,
  input  logic       U1_LOCKED,
  input  logic       U2_LOCKED,
  input  logic       SOFT_RST,
  output logic       U2_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT
);

  localparam int unsigned TW = 16;
  localparam int unsigned RW = 4;

  localparam logic [TW-1:0] PULSE_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_WAIT_U1,
    S_PULSE,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        r_state;
  state_t        w_nxt_state;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_nxt_timer;
  logic [RW-1:0] r_retry_cnt;
  logic [RW-1:0] w_nxt_retry;
  logic          w_retry_evt;

  logic r_u1_meta;
  logic r_u1_s;
  logic r_u2_meta;
  logic r_u2_s;

  logic r_u2_rst;
  logic r_sys_rst;
  logic r_ready;
  logic r_fail;

  // Two-flop synchronisers for the asynchronous lock inputs
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_u1_meta <= 1'b0;
      r_u1_s    <= 1'b0;
      r_u2_meta <= 1'b0;
      r_u2_s    <= 1'b0;
    end else begin
      r_u1_meta <= U1_LOCKED;
      r_u1_s    <= r_u1_meta;
      r_u2_meta <= U2_LOCKED;
      r_u2_s    <= r_u2_meta;
    end
  end

  // State, shared timer, retry counter and next-state output decodes
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_state     <= S_WAIT_U1;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_u2_rst    <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_timer     <= w_nxt_timer;
      r_retry_cnt <= w_nxt_retry;
      r_u2_rst    <= (w_nxt_state == S_WAIT_U1) || (w_nxt_state == S_PULSE) ||
                     (w_nxt_state == S_FAIL);
      r_sys_rst   <= (w_nxt_state != S_RUN);
      r_ready     <= (w_nxt_state == S_RUN);
      r_fail      <= (w_nxt_state == S_FAIL);
    end
  end

  // Next state: SOFT_RST beats U1 loss, which beats timer/lock events
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    w_nxt_retry = r_retry_cnt;
    w_retry_evt = 1'b0;

    if (SOFT_RST || ((r_state != S_WAIT_U1) && !r_u1_s)) begin
      w_nxt_state = S_WAIT_U1;
      w_nxt_timer = '0;
      w_nxt_retry = '0;
    end else begin
      case (r_state)
        S_WAIT_U1: begin
          if (r_u1_s) begin
            w_nxt_state = S_PULSE;
            w_nxt_timer = '0;
          end
        end
        S_PULSE: begin
          if (r_timer == PULSE_LAST) begin
            w_nxt_state = S_WAIT_LOCK;
            w_nxt_timer = '0;
          end else begin
            w_nxt_timer = r_timer + TW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (r_u2_s) begin
            w_nxt_state = S_SETTLE;
            w_nxt_timer = '0;
          end else if (r_timer == LOCK_LAST) begin
            w_retry_evt = 1'b1;
          end else begin
            w_nxt_timer = r_timer + TW'(1);
          end
        end
        S_SETTLE: begin
          if (!r_u2_s) begin
            w_retry_evt = 1'b1;
          end else if (r_timer == SETTLE_LAST) begin
            w_nxt_state = S_RUN;
            w_nxt_timer = '0;
          end else begin
            w_nxt_timer = r_timer + TW'(1);
          end
        end
        S_RUN: begin
          if (!r_u2_s) begin
            w_nxt_state = S_PULSE;
            w_nxt_timer = '0;
            w_nxt_retry = '0;
          end
        end
        S_FAIL: begin
          w_nxt_timer = '0;
        end
        default: begin
          w_nxt_state = S_WAIT_U1;
          w_nxt_timer = '0;
          w_nxt_retry = '0;
        end
      endcase

      if (w_retry_evt) begin
        w_nxt_timer = '0;
        if (r_retry_cnt == RETRY_MAX) begin
          w_nxt_state = S_FAIL;
        end else begin
          w_nxt_state = S_PULSE;
          w_nxt_retry = r_retry_cnt + RW'(1);
        end
      end
    end
  end

  assign U2_RST    = r_u2_rst;
  assign SYS_RST   = r_sys_rst;
  assign READY     = r_ready;
  assign FAIL      = r_fail;
  assign RETRY_CNT = r_retry_cnt;

`ifdef DCM_LOCK_LOSS_CNT_EN
  localparam int unsigned LW = 8;

  logic [LW-1:0] r_loss_cnt;
  logic          w_loss_evt;

  // Counts only the RUN -> PULSE transition, so it must lose to SOFT_RST and U1 loss
  assign w_loss_evt = !SOFT_RST && r_u1_s && (r_state == S_RUN) && !r_u2_s;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + LW'(1);
    end
  end

  assign LOSS_CNT = r_loss_cnt;
`else
  assign LOSS_CNT = '0;
`endif

endmodule

// File: doc/dcm_lock_ctrl.md
DCM_LOCK_CTRL -- requirements
Module: dcm_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: U2 DCM reset pulse length in BUS_CLK cycles, range 1..65535.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: cycles allowed for U2 lock after its reset pulse, range 1..65535.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256: cycles U2 lock must stay high before release, range 1..65535.
REQ-004 SHALL have parameter MAX_RETRY, default 7: maximum U2 reset retries before FAIL, range 0..15.
REQ-005 SHALL have port BUS_CLK  in  1  single clock for all logic.
REQ-006 SHALL have port BUS_RST_N  in  1  asynchronous active-low reset.
REQ-007 SHALL have port U1_LOCKED  in  1  first DCM lock, asynchronous.
REQ-008 SHALL have port U2_LOCKED  in  1  second DCM lock, asynchronous.
REQ-009 SHALL have port SOFT_RST  in  1  synchronous one-cycle restart request.
REQ-010 SHALL have port U2_RST  out  1  active-high reset to second DCM.
REQ-011 SHALL have port SYS_RST  out  1  active-high reset for logic clocked by U2 clocks.
REQ-012 SHALL have port READY  out  1  high only in RUN.
REQ-013 SHALL have port FAIL  out  1  high only in FAIL.
REQ-014 SHALL have port RETRY_CNT  out  4  retries consumed in current bring-up.
REQ-015 SHALL have port LOSS_CNT  out  8  U2 lock-loss events while in RUN.

Function
REQ-016 SHALL synchronise U1_LOCKED and U2_LOCKED through 2-flop synchronisers; u1_s/u2_s below are the synchronised values, 2-cycle latency.
REQ-017 SHALL implement states WAIT_U1, PULSE, WAIT_LOCK, SETTLE, RUN, FAIL with one shared 16-bit cycle timer.
REQ-018 WAIT_U1: on u1_s=1, go to PULSE, timer=0.
REQ-019 PULSE: after exactly RST_CYCLES cycles in PULSE, go to WAIT_LOCK, timer=0.
REQ-020 WAIT_LOCK: u2_s=1 -> SETTLE, timer=0; else timer reaches LOCK_TIMEOUT-1 -> retry event.
REQ-021 SETTLE: u2_s held 1 for SETTLE_CYCLES consecutive cycles -> RUN; any u2_s=0 -> retry event.
REQ-022 Retry event: if RETRY_CNT=MAX_RETRY go to FAIL, else RETRY_CNT+1 and go to PULSE, timer=0.
REQ-023 RUN: u2_s=0 -> PULSE, RETRY_CNT=0, LOSS_CNT+1 (saturating at 255).
REQ-024 FAIL: remains until SOFT_RST or u1_s=0.
REQ-025 In any state except WAIT_U1, u1_s=0 -> WAIT_U1, RETRY_CNT=0.
REQ-026 SOFT_RST=1 in any state -> WAIT_U1, RETRY_CNT=0, FAIL=0; LOSS_CNT unchanged; priority over all other transitions.
REQ-027 Priority when simultaneous: SOFT_RST > u1_s loss > timer/u2_s events.
REQ-028 Outputs SHALL be registered decodes of next state, changing on the same edge as the state register.
REQ-029 U2_RST SHALL be 1 in WAIT_U1, PULSE, FAIL; 0 otherwise.
REQ-030 SYS_RST SHALL be 0 only in RUN; first cycle of READY=1 equals first cycle of SYS_RST=0.

Reset
REQ-031 BUS_RST_N=0 SHALL asynchronously force WAIT_U1, timer=0, synchronisers=0, U2_RST=1, SYS_RST=1, READY=0, FAIL=0, RETRY_CNT=0, LOSS_CNT=0.
REQ-032 Reset release SHALL be synchronous to BUS_CLK; reset mid-bring-up SHALL restart from WAIT_U1 with no retained retry state.

Configuration
REQ-033 Macro DCM_LOCK_LOSS_CNT_EN defined: LOSS_CNT implemented per REQ-023/026/031.
REQ-034 Macro DCM_LOCK_LOSS_CNT_EN undefined: LOSS_CNT tied to 0, no counter flops; all other behaviour identical.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=8, MAX_RETRY=2)
REQ-035 U1 lock at t0, U2 lock 10 cycles after U2_RST falls -> U2_RST high 4 cycles, READY=1/SYS_RST=0 at lock+2 sync+8 settle, RETRY_CNT=0.
REQ-036 U2_LOCKED never asserts -> three PULSE/WAIT_LOCK cycles of 100 cycles each, RETRY_CNT 0->1->2, then FAIL=1, U2_RST=1; SOFT_RST -> WAIT_U1, FAIL=0.
REQ-037 U2 lock drops 3 cycles into SETTLE -> RETRY_CNT=1, new 4-cycle U2_RST pulse, READY stays 0.
REQ-038 In RUN, U2_LOCKED low 1 cycle -> SYS_RST=1, READY=0, LOSS_CNT=1, RETRY_CNT=0, re-lock reaches RUN; with macro undefined LOSS_CNT=0.
REQ-039 SOFT_RST coincident with timeout in WAIT_LOCK at RETRY_CNT=2 -> WAIT_U1, FAIL stays 0; U1 loss in RUN -> WAIT_U1, U2_RST=1.
REQ-040 BUS_RST_N pulsed low mid-PULSE -> all outputs at reset values immediately, bring-up restarts with full 4-cycle pulse.
